// File: rtl/seq_divider_32bit_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_32bit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface seq_divider_32bit_if #(parameter int unsigned WIDTH = seq_div_pkg::WIDTH_DEF);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/seq_divider_32bit_div_step.sv
// One restoring-division step: shift in next dividend bit, trial subtract, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff_lo;
    logic             w_diff_unused;
    logic             w_borrow;

    always_comb begin
        w_sh = {i_rem, i_quo[WIDTH-1]};
        {w_borrow, w_diff_unused, w_diff_lo} = {1'b0, w_sh} - {2'b00, i_div};
        o_rem = w_borrow ? w_sh[WIDTH-1:0] : w_diff_lo;
        o_quo = {i_quo[WIDTH-2:0], ~w_borrow};
    end

endmodule

// File: rtl/seq_divider_32bit.sv
// Multi-cycle restoring divider, WIDTH+1 cycle fixed latency.
// Define SEQ_DIV_SIGNED_EN to honour is_signed (two's complement DIV); otherwise unsigned only.
module seq_divider_32bit
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    seq_divider_32bit_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

`ifdef SEQ_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_sa;
    logic w_sb;

    // Divide magnitudes; signs are reapplied on the done edge (truncate toward zero).
    always_comb begin
        w_sa    = bus.is_signed & bus.dividend[WIDTH-1];
        w_sb    = bus.is_signed & bus.divisor[WIDTH-1];
        w_a_mag = w_sa ? (~bus.dividend + 1'b1) : bus.dividend;
        w_b_mag = w_sb ? (~bus.divisor + 1'b1) : bus.divisor;
        w_q_fix = r_zero ? '1 : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
        w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    end
`else
    logic w_unused_is_signed;

    // Divide-by-zero falls out of the restoring loop: quo=all ones, rem=dividend.
    always_comb begin
        w_unused_is_signed = bus.is_signed;
        w_a_mag            = bus.dividend;
        w_b_mag            = bus.divisor;
        w_q_fix            = r_quo;
        w_r_fix            = r_rem;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_div_zero  <= r_zero;
                        r_done      <= 1'b1;
                    end
                    if (bus.start) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_zero  <= (bus.divisor == '0);
                        r_cnt   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
`endif
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Scoreboard bench for seq_divider_32bit: driver pushes expected results, monitor pops on done.
module tb_seq_divider_32bit;

    logic clk;
    logic reset;
    int unsigned cyc;
    int unsigned errors;
    int unsigned checks;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];

    seq_divider_32bit_if #(.WIDTH(32)) bus ();

    seq_divider_32bit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural operand values.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb_v, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            if (sgn) begin
                sa   = longint'($signed(a));
                sb_v = longint'($signed(b));
                sq   = sa / sb_v;
                sr   = sa % sb_v;
                q    = sq[31:0];
                r    = sr[31:0];
            end else begin
                q = a / b;
                r = a % b;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // Caller must be at a negedge; returns at the negedge where busy has dropped (DONE state).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit poke);
        exp_t e;
        int unsigned n;
        bus.start     = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        model(a, b, sgn, e.q, e.r);
        e.z   = (b == 32'd0);
        e.acc = cyc;
        sb.push_back(e);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.start) bus.start = 1'b0;
            if (!bus.busy) break;
            n++;
            if (poke && n == 10) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd999;
                bus.divisor  = 32'd1;
            end
        end
        bus.start = 1'b0;
        check("busy_cycles", n, 32);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.z});
                check("latency", cyc - e.acc, 32'd33);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        cyc           = 0;
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        run_op(32'h1234, 32'd0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op(32'd0, 32'd5, 1'b0, 1'b0);
        run_op(32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op(32'd1000, 32'd3, 1'b0, 1'b1);

        // Abort mid-operation: no done may follow, outputs return to zero.
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_div_zero", {31'd0, bus.div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 15);
                1:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
